// File: rtl/keypad_entry_pkg.sv
// keypad_entry_pkg: key codes, scanner states and key map shared by the keypad entry path.
package keypad_entry_pkg;
  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} scan_state_t;
  localparam logic [3:0] KEY_CLR = 4'hA;
  localparam logic [3:0] KEY_BS  = 4'hE;
  localparam logic [3:0] KEY_ENT = 4'hF;
  localparam int NUM_DIGITS = 4;
  // nibble {row,col} holds the key code; row 0 col 0 is the LSB nibble
  localparam logic [63:0] KEY_LUT = 64'hDF0E_C987_B654_A321;
  function automatic logic [3:0] key_lookup(input logic [1:0] row, input logic [1:0] col);
    return KEY_LUT[{row, col, 2'b00} +: 4];
  endfunction
endpackage

// File: rtl/cdiv_tick.sv
// cdiv_tick: one-clock tick every DIV clocks.
module cdiv_tick #(
  parameter int DIV = 10_000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  output logic o_tick
);
  localparam int W = DIV > 1 ? $clog2(DIV) : 1;
  logic [W-1:0] r_cnt;
  logic         w_wrap;
  assign w_wrap = r_cnt == W'(DIV - 1);
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt  <= '0;
      o_tick <= 1'b0;
    end else begin
      o_tick <= w_wrap;
      r_cnt  <= w_wrap ? '0 : r_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: row synchroniser, column rotation and press/release debounce for a 4x4 keypad.
module keypad_scanner
  import keypad_entry_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_tick,
  input  logic [3:0] i_row,
  output logic [3:0] o_col,
  output logic       o_valid,
  output logic [3:0] o_code
);
  localparam int CW = $clog2(DEBOUNCE_TICKS);
  scan_state_t r_state;
  logic [3:0]  r_s1, r_s2;
  logic [1:0]  r_ri;
  logic [CW-1:0] r_cnt;
  logic [3:0]  w_low, w_rot;
  logic        w_one, w_same;
  logic [1:0]  w_ri, w_ci;
  assign w_low  = ~r_s2;
  assign w_one  = (w_low != 4'h0) && ((w_low & (w_low - 4'h1)) == 4'h0);
  assign w_ri   = w_low[1] ? 2'd1 : w_low[2] ? 2'd2 : w_low[3] ? 2'd3 : 2'd0;
  assign w_ci   = !o_col[1] ? 2'd1 : !o_col[2] ? 2'd2 : !o_col[3] ? 2'd3 : 2'd0;
  assign w_same = r_s2 == ~(4'b0001 << r_ri);
  assign w_rot  = {o_col[2:0], o_col[3]};
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1    <= 4'hF;
      r_s2    <= 4'hF;
      r_state <= SCAN;
      r_ri    <= 2'd0;
      r_cnt   <= '0;
      o_col   <= 4'b1110;
      o_valid <= 1'b0;
      o_code  <= 4'h0;
    end else begin
      r_s1    <= i_row;
      r_s2    <= r_s1;
      o_valid <= 1'b0;
      if (i_tick) begin
        case (r_state)
          SCAN: begin
            if (w_one) begin
              r_ri    <= w_ri;
              r_cnt   <= '0;
              r_state <= DEBOUNCE;
            end else o_col <= w_rot;
          end
          DEBOUNCE: begin
            if (!w_same) begin
              o_col   <= w_rot;
              r_state <= SCAN;
            end else if (r_cnt == CW'(DEBOUNCE_TICKS - 2)) begin
              o_valid <= 1'b1;
              o_code  <= key_lookup(r_ri, w_ci);
              r_cnt   <= '0;
              r_state <= HELD;
            end else r_cnt <= r_cnt + 1'b1;
          end
          HELD: begin
            // release needs an unbroken run of idle rows; column stays put until then
            if (r_s2 != 4'hF) r_cnt <= '0;
            else if (r_cnt == CW'(DEBOUNCE_TICKS - 1)) begin
              o_col   <= w_rot;
              r_state <= SCAN;
            end else r_cnt <= r_cnt + 1'b1;
          end
          default: r_state <= SCAN;
        endcase
      end
    end
  end
endmodule

// File: rtl/keypad_entry.sv
// keypad_entry: scanned keypad to 4-digit BCD entry with live binary value and commit on Enter.
module keypad_entry
  import keypad_entry_pkg::*;
#(
  parameter int DIV_SCAN       = 10_000,
  parameter int DEBOUNCE_TICKS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  key_row,
  output logic [3:0]  key_col,
  output logic        key_valid,
  output logic [3:0]  key_code,
  output logic [13:0] entry_val,
  output logic [13:0] out_val,
  output logic        out_valid
);
  logic        w_tick;
  logic [15:0] r_bcd;
  logic [2:0]  r_cnt;
  cdiv_tick #(.DIV(DIV_SCAN)) u_div (
    .i_clk(clk), .i_rst_n(rst), .o_tick(w_tick)
  );
  keypad_scanner #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_scan (
    .i_clk(clk), .i_rst_n(rst), .i_tick(w_tick), .i_row(key_row),
    .o_col(key_col), .o_valid(key_valid), .o_code(key_code)
  );
  assign entry_val = 14'(r_bcd[15:12]) * 14'd1000 + 14'(r_bcd[11:8]) * 14'd100
                   + 14'(r_bcd[7:4]) * 14'd10 + 14'(r_bcd[3:0]);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bcd     <= 16'h0;
      r_cnt     <= 3'd0;
      out_val   <= 14'd0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (key_valid) begin
        if (key_code < 4'd10) begin
          if (r_cnt < 3'(NUM_DIGITS)) begin
            r_bcd <= {r_bcd[11:0], key_code};
            r_cnt <= r_cnt + 3'd1;
          end
        end else if (key_code == KEY_BS) begin
          if (r_cnt != 3'd0) begin
            r_bcd <= {4'h0, r_bcd[15:4]};
            r_cnt <= r_cnt - 3'd1;
          end
        end else if (key_code == KEY_CLR) begin
          r_bcd <= 16'h0;
          r_cnt <= 3'd0;
        end else if (key_code == KEY_ENT) begin
          out_val   <= entry_val;
          out_valid <= 1'b1;
          r_bcd     <= 16'h0;
          r_cnt     <= 3'd0;
        end
      end
    end
  end
endmodule

// File: tb/tb_keypad_entry.sv
// tb_keypad_entry: keypad matrix model plus decimal-arithmetic entry model checking keypad_entry.
module tb_keypad_entry;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  key_row, key_col, key_code;
  logic        key_valid, out_valid;
  logic [13:0] entry_val, out_val;
  logic [15:0] pressed = 16'h0;
  int total = 0, bad = 0, kv_cnt = 0, ov_cnt = 0;
  int m_val = 0, m_n = 0, m_out = 0, m_ov = 0;
  int lut[16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};

  keypad_entry #(.DIV_SCAN(4), .DEBOUNCE_TICKS(3)) dut (
    .clk(clk), .rst(rst), .key_row(key_row), .key_col(key_col), .key_valid(key_valid),
    .key_code(key_code), .entry_val(entry_val), .out_val(out_val), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  // a pressed switch pulls its row low while its column is driven low
  always_comb begin
    key_row = 4'hF;
    for (int i = 0; i < 16; i++)
      if (pressed[i[3:0]] && !key_col[i[1:0]]) key_row[i[3:2]] = 1'b0;
  end

  always @(negedge clk) begin
    if (key_valid) kv_cnt++;
    if (out_valid) ov_cnt++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  function automatic int idx_of(input int code);
    for (int i = 0; i < 16; i++) if (lut[i] == code) return i;
    return 0;
  endfunction

  task automatic model(input int code);
    if (code < 10) begin
      if (m_n < 4) begin
        m_val = m_val * 10 + code;
        m_n++;
      end
    end else if (code == 14) begin
      if (m_n > 0) begin
        m_val = m_val / 10;
        m_n--;
      end
    end else if (code == 10) begin
      m_val = 0;
      m_n = 0;
    end else if (code == 15) begin
      m_out = m_val;
      m_ov++;
      m_val = 0;
      m_n = 0;
    end
  endtask

  task automatic check_state(input string tag);
    chk($sformatf("%s_entry", tag), int'(entry_val), m_val);
    chk($sformatf("%s_out_val", tag), int'(out_val), m_out);
    chk($sformatf("%s_out_pulses", tag), ov_cnt, m_ov);
  endtask

  task automatic wait_kv(input int k0, input int lim);
    for (int n = 0; n < lim && kv_cnt == k0; n++) @(negedge clk);
  endtask

  task automatic press(input int code, input int hold);
    int k0, i;
    k0 = kv_cnt;
    i = idx_of(code);
    pressed[i[3:0]] = 1'b1;
    wait_kv(k0, 400);
    repeat (hold) @(negedge clk);
    pressed[i[3:0]] = 1'b0;
    repeat (60) @(negedge clk);
    chk($sformatf("kv_pulses_%0d", code), kv_cnt - k0, 1);
    chk($sformatf("key_code_%0d", code), int'(key_code), code);
    model(code);
    check_state($sformatf("key%0d", code));
  endtask

  initial begin
    int k0, changes;
    logic [3:0] prev;
    repeat (3) @(negedge clk);
    chk("rst_col", int'(key_col), 14);
    chk("rst_kv", int'(key_valid), 0);
    chk("rst_code", int'(key_code), 0);
    chk("rst_entry", int'(entry_val), 0);
    chk("rst_out_val", int'(out_val), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    rst = 1'b1;
    repeat (5) @(negedge clk);

    foreach (lut[j]) if (j < 4) press(j + 1, 4);
    press(15, 4);
    foreach (lut[j]) if (j < 5) press(9 - j, 8);
    press(14, 3);
    press(10, 3);

    // bounces shorter than the debounce window must not register
    k0 = kv_cnt;
    repeat (5) begin
      for (int n = 0; n < 100 && key_col != 4'hD; n++) @(negedge clk);
      pressed[9] = 1'b1;
      repeat (6) @(negedge clk);
      pressed[9] = 1'b0;
      repeat (24) @(negedge clk);
    end
    chk("bounce_kv", kv_cnt - k0, 0);
    press(8, 10);

    k0 = kv_cnt;
    pressed[5] = 1'b1;
    wait_kv(k0, 400);
    repeat (200) @(negedge clk);
    chk("held_col", int'(key_col), 13);
    pressed[6] = 1'b1;
    repeat (100) @(negedge clk);
    chk("held_kv", kv_cnt - k0, 1);
    chk("held_code", int'(key_code), 5);
    pressed = 16'h0;
    for (int n = 0; n < 100 && key_col == 4'hD; n++) @(negedge clk);
    chk("scan_resume", int'(key_col != 4'hD), 1);
    model(5);
    repeat (60) @(negedge clk);
    check_state("held");

    k0 = kv_cnt;
    changes = 0;
    pressed[1] = 1'b1;
    pressed[5] = 1'b1;
    prev = key_col;
    repeat (200) begin
      @(negedge clk);
      if (key_col != prev) changes++;
      prev = key_col;
    end
    chk("multi_kv", kv_cnt - k0, 0);
    chk("multi_rotate", int'(changes >= 40), 1);
    pressed = 16'h0;
    repeat (40) @(negedge clk);

    repeat (20) press(int'($urandom_range(0, 15)), int'($urandom_range(0, 30)));

    press(7, 2);
    press(15, 2);
    press(10, 2);
    press(4, 2);
    press(2, 2);
    k0 = kv_cnt;
    pressed[7] = 1'b1;
    wait_kv(k0, 400);
    repeat (10) @(negedge clk);
    rst = 1'b0;
    #2;
    chk("mid_rst_col", int'(key_col), 14);
    chk("mid_rst_entry", int'(entry_val), 0);
    chk("mid_rst_out_val", int'(out_val), 0);
    chk("mid_rst_kv", int'(key_valid), 0);
    pressed = 16'h0;
    repeat (10) @(negedge clk);
    chk("in_rst_col", int'(key_col), 14);
    chk("in_rst_entry", int'(entry_val), 0);
    rst = 1'b1;
    m_val = 0;
    m_n = 0;
    m_out = 0;
    repeat (40) @(negedge clk);
    chk("post_rst_kv", kv_cnt - k0, 1);
    check_state("post_rst");
    press(3, 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
